// File: rtl/pl_mem_pkg.sv
// Shared constants for the memory stage: funct3 size codes,
// the ResultSrc load code and the bus FSM state encoding.
package pl_mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RS_LOAD = 2'b01;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_WAIT = 2'b01,
      ST_ERR  = 2'b10
   } state_e;

   // Anything that is not a byte or half access is a word access
   function automatic size_e size_of(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         default:     return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/pl_mem_if.sv
// Data-memory req/ack bus between the memory stage (master)
// and the data memory (slave).
interface pl_mem_if;

   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_be;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
      output bus_rdata, bus_ack
   );

endinterface

// File: rtl/pl_load_extend.sv
// Load data alignment: picks the addressed byte/half lane out of
// the bus word and sign- or zero-extends it; other codes pass the word.
module pl_load_extend
   import pl_mem_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  lane_i,
   input  logic [2:0]  funct3_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   // Lane select then extension by funct3
   always_comb begin
      byte_w = rdata_i[{lane_i, 3'b000} +: 8];
      half_w = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (funct3_i)
         F3_B:    data_o = {{24{byte_w[7]}}, byte_w};
         F3_BU:   data_o = {24'h0, byte_w};
         F3_H:    data_o = {{16{half_w[15]}}, half_w};
         F3_HU:   data_o = {16'h0, half_w};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/pl_mem_stage.sv
// Memory stage + MEM|WB register with req/ack bus, stall and timeout.
// Optional PL_MEM_MISALIGN_TRAP_EN: trap misaligned H/W, add MisalignW.
module pl_mem_stage
   import pl_mem_pkg::*;
#(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   input  logic [2:0]  funct3M,
   input  logic [4:0]  RdM,
   input  logic [31:0] PCPlus4M,
   input  logic [31:0] lAuiPCM,
   pl_mem_if.master    bus,
   output logic        StallM,
   output logic        BusErr,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [31:0] ALUResultW,
   output logic [31:0] ReadDataW,
   output logic [4:0]  RdW,
   output logic [31:0] PCPlus4W,
`ifdef PL_MEM_MISALIGN_TRAP_EN
   output logic [31:0] lAuiPCW,
   output logic        MisalignW
`else
   output logic [31:0] lAuiPCW
`endif
);

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   size_e            sz;
   logic             memop;
   logic             mis;
   logic             err;
   logic             req;
   logic             ack;
   logic [3:0]       be_d;
   logic [31:0]      wd_d;
   logic [31:0]      ld_data;

   assign sz    = size_of(funct3M);
   assign memop = MemWriteM | (ResultSrcM == RS_LOAD);
   assign err   = (state_q == ST_ERR);

`ifdef PL_MEM_MISALIGN_TRAP_EN
   assign mis = memop &
                (((sz == SZ_H) & ALUResultM[0]) |
                 ((sz == SZ_W) & (ALUResultM[1:0] != 2'b00)));
`else
   assign mis = 1'b0;
`endif

   // rst_n gates the request so it drops the moment reset asserts
   assign req    = rst_n & memop & ~mis & ~err;
   assign ack    = req & bus.bus_ack;
   assign StallM = req & ~bus.bus_ack;

   // Byte-lane steering of store data and enables
   always_comb begin
      be_d = 4'b1111;
      wd_d = '0;
      if (MemWriteM) begin
         case (sz)
            SZ_B: begin
               be_d = 4'b0001 << ALUResultM[1:0];
               wd_d = {4{WriteDataM[7:0]}};
            end
            SZ_H: begin
               be_d = 4'b0011 << {ALUResultM[1], 1'b0};
               wd_d = {2{WriteDataM[15:0]}};
            end
            default: begin
               be_d = 4'b1111;
               wd_d = WriteDataM;
            end
         endcase
      end
   end

   assign bus.bus_req   = req;
   assign bus.bus_we    = req & MemWriteM;
   assign bus.bus_addr  = req ? {ALUResultM[31:2], 2'b00} : '0;
   assign bus.bus_be    = req ? be_d : '0;
   assign bus.bus_wdata = req ? wd_d : '0;

   pl_load_extend u_ext (
      .rdata_i  (bus.bus_rdata),
      .lane_i   (ALUResultM[1:0]),
      .funct3_i (funct3M),
      .data_o   (ld_data)
   );

   // Bus FSM: wait for ack, abort to ERR after TIMEOUT stalled cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         BusErr  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req && !ack) begin
                  state_q <= ST_WAIT;
                  cnt_q   <= CNT_W'(1);
               end
            end
            ST_WAIT: begin
               if (ack || !req) begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q <= ST_ERR;
                  cnt_q   <= '0;
                  BusErr  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   // MEM|WB register: bubble while stalled, else capture the retiring op
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= '0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         RdW        <= '0;
         PCPlus4W   <= '0;
         lAuiPCW    <= '0;
      end else if (StallM) begin
         RegWriteW <= 1'b0;
         RdW       <= '0;
      end else begin
         RegWriteW  <= RegWriteM & ~err & ~mis;
         ResultSrcW <= ResultSrcM;
         ALUResultW <= ALUResultM;
         ReadDataW  <= (ack & ~MemWriteM) ? ld_data : '0;
         RdW        <= RdM;
         PCPlus4W   <= PCPlus4M;
         lAuiPCW    <= lAuiPCM;
      end
   end

`ifdef PL_MEM_MISALIGN_TRAP_EN
   // Sticky misalignment flag, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         MisalignW <= 1'b0;
      end else if (mis) begin
         MisalignW <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pl_mem_stage.sv
// Bench for pl_mem_stage: spec-level model checked every cycle
// plus directed vectors with hand-computed literal expectations.
module tb_pl_mem_stage;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        RegWriteM = 1'b0;
   logic        MemWriteM = 1'b0;
   logic [1:0]  ResultSrcM = '0;
   logic [31:0] ALUResultM = '0;
   logic [31:0] WriteDataM = '0;
   logic [2:0]  funct3M = '0;
   logic [4:0]  RdM = '0;
   logic [31:0] PCPlus4M = '0;
   logic [31:0] lAuiPCM = '0;
   logic        StallM, BusErr, RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W, lAuiPCW;
   logic [4:0]  RdW;
`ifdef PL_MEM_MISALIGN_TRAP_EN
   logic        MisalignW;
`endif

   pl_mem_if bus ();

   always #5 clk = ~clk;

   pl_mem_stage #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .funct3M    (funct3M),
      .RdM        (RdM),
      .PCPlus4M   (PCPlus4M),
      .lAuiPCM    (lAuiPCM),
      .bus        (bus.master),
      .StallM     (StallM),
      .BusErr     (BusErr),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .RdW        (RdW),
      .PCPlus4W   (PCPlus4W),
`ifdef PL_MEM_MISALIGN_TRAP_EN
      .lAuiPCW    (lAuiPCW),
      .MisalignW  (MisalignW)
`else
      .lAuiPCW    (lAuiPCW)
`endif
   );

   int n_vec = 0;
   int n_bad = 0;
   bit go = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- spec-level model ----------------
   function automatic int bytes_of(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic logic mis_of(input logic mem, input logic [31:0] a,
                                   input logic [2:0] f3);
`ifdef PL_MEM_MISALIGN_TRAP_EN
      if (!mem) return 1'b0;
      if (bytes_of(f3) == 2) return a[0];
      if (bytes_of(f3) == 4) return (a % 4) != 0;
      return 1'b0;
`else
      return 1'b0 & mem & a[0] & f3[0];
`endif
   endfunction

   function automatic logic [31:0] load_of(input logic [31:0] rd,
                                           input logic [31:0] a,
                                           input logic [2:0] f3);
      logic [31:0] v;
      v = rd;
      if (bytes_of(f3) == 1) begin
         v = (rd >> (8 * int'(a % 4))) & 32'hFF;
         if (!f3[2] && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end else if (bytes_of(f3) == 2) begin
         v = (rd >> (16 * int'((a / 2) % 2))) & 32'hFFFF;
         if (!f3[2] && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      return v;
   endfunction

   function automatic logic [3:0] be_of(input logic we, input logic [31:0] a,
                                        input logic [2:0] f3);
      if (!we || bytes_of(f3) == 4) return 4'hF;
      if (bytes_of(f3) == 1) return 4'(1 << (a % 4));
      return 4'(3 << (2 * ((a / 2) % 2)));
   endfunction

   function automatic logic [31:0] wd_of(input logic we, input logic [31:0] d,
                                         input logic [2:0] f3);
      if (!we) return 32'h0;
      if (bytes_of(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (bytes_of(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   logic        m_err = 1'b0;
   int          m_wait = 0;
   logic        eRW = 1'b0, eBusErr = 1'b0, eMis = 1'b0;
   logic [1:0]  eRS = '0;
   logic [31:0] eALU = '0, eRD = '0, ePC = '0, eAui = '0;
   logic [4:0]  eRd = '0;
   logic        m_mem, m_mis, m_req;

   assign m_mem = MemWriteM | (ResultSrcM == 2'b01);
   assign m_mis = mis_of(m_mem, ALUResultM, funct3M);
   assign m_req = rst_n & m_mem & ~m_mis & ~m_err;

   // What the spec says the stage must retire at each edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_err <= 1'b0; m_wait <= 0; eBusErr <= 1'b0; eMis <= 1'b0;
         eRW <= 1'b0; eRS <= '0; eALU <= '0; eRD <= '0;
         eRd <= '0; ePC <= '0; eAui <= '0;
      end else if (m_req && !bus.bus_ack) begin
         eRW <= 1'b0;
         eRd <= '0;
         if (m_wait + 1 == TIMEOUT) begin
            m_err <= 1'b1; eBusErr <= 1'b1; m_wait <= 0;
         end else begin
            m_wait <= m_wait + 1;
         end
      end else begin
         eRW  <= RegWriteM & ~m_err & ~m_mis;
         eRS  <= ResultSrcM;
         eALU <= ALUResultM;
         eRd  <= RdM;
         ePC  <= PCPlus4M;
         eAui <= lAuiPCM;
         eRD  <= (m_req && bus.bus_ack && !MemWriteM) ?
                 load_of(bus.bus_rdata, ALUResultM, funct3M) : 32'h0;
         m_err <= 1'b0;
         m_wait <= 0;
         if (m_mis) eMis <= 1'b1;
      end
   end

   // Every-cycle compare against the model, away from the clock edge
   always @(negedge clk) begin
      if (go) begin
         chk("bus_req", bus.bus_req, m_req);
         chk("bus_we", bus.bus_we, m_req & MemWriteM);
         chk("bus_addr", bus.bus_addr, m_req ? (ALUResultM & ~32'h3) : 0);
         chk("bus_be", bus.bus_be,
             m_req ? be_of(MemWriteM, ALUResultM, funct3M) : 4'h0);
         chk("bus_wdata", bus.bus_wdata,
             m_req ? wd_of(MemWriteM, WriteDataM, funct3M) : 0);
         chk("StallM", StallM, m_req & ~bus.bus_ack);
         chk("BusErr", BusErr, eBusErr);
         chk("RegWriteW", RegWriteW, eRW);
         chk("ResultSrcW", ResultSrcW, eRS);
         chk("ALUResultW", ALUResultW, eALU);
         chk("ReadDataW", ReadDataW, eRD);
         chk("RdW", RdW, eRd);
         chk("PCPlus4W", PCPlus4W, ePC);
         chk("lAuiPCW", lAuiPCW, eAui);
`ifdef PL_MEM_MISALIGN_TRAP_EN
         chk("MisalignW", MisalignW, eMis);
`endif
      end
   end

   // ---------------- directed stimulus ----------------
   int          stalls;
   logic [3:0]  cap_be;
   logic [31:0] cap_wd;

   // One memory op held (as a stalled pipeline would) until it retires;
   // dly = cycle of ack, -1 = never acked
   task automatic op(input logic we, input logic [1:0] rs,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f3, input logic [4:0] rd,
                     input logic rw, input int dly,
                     input logic [31:0] rdat);
      int n;
      n = (dly >= 0) ? dly + 1 : TIMEOUT + 1;
      stalls = 0;
      cap_be = '0;
      cap_wd = '0;
      @(posedge clk); #1;
      MemWriteM = we; ResultSrcM = rs; ALUResultM = a; WriteDataM = d;
      funct3M = f3; RdM = rd; RegWriteM = rw;
      PCPlus4M = a + 4; lAuiPCM = a ^ 32'h5A5A_0000;
      bus.bus_rdata = rdat;
      for (int i = 0; i < n; i++) begin
         bus.bus_ack = (i == dly);
         @(negedge clk);
         if (StallM) stalls++;
         if (bus.bus_req) begin
            cap_be = bus.bus_be;
            cap_wd = bus.bus_wdata;
         end
         if (i < n - 1) begin
            @(posedge clk); #1;
         end
      end
      @(posedge clk); #1;
      MemWriteM = 1'b0; ResultSrcM = 2'b00; RegWriteM = 1'b0;
      bus.bus_ack = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      bus.bus_ack = 1'b0;
      bus.bus_rdata = '0;
      MemWriteM = 1'b1;
      ALUResultM = 32'h40;
      repeat (2) @(negedge clk);
      chk("rst_bus_req", bus.bus_req, 0);
      chk("rst_stall", StallM, 0);
      chk("rst_buserr", BusErr, 0);
      chk("rst_rdw", RdW, 0);
      @(posedge clk); #1;
      MemWriteM = 1'b0;
      rst_n = 1'b1;
      go = 1'b1;

      // 1: SW zero-wait
      op(1, 2'b00, 32'h100, 32'hDEAD_BEEF, 3'b010, 5'd0, 0, 0, 0);
      chk("sw_be", cap_be, 4'hF);
      chk("sw_wdata", cap_wd, 32'hDEAD_BEEF);
      chk("sw_stalls", stalls, 0);

      // 2: SB ack after 3 cycles
      op(1, 2'b00, 32'h103, 32'h0000_005A, 3'b000, 5'd0, 0, 3, 0);
      chk("sb_be", cap_be, 4'b1000);
      chk("sb_wdata", cap_wd, 32'h5A5A_5A5A);
      chk("sb_stalls", stalls, 3);

      // 3: LB / LBU
      op(0, 2'b01, 32'h101, 0, 3'b000, 5'd3, 1, 1, 32'h0000_8000);
      chk("lb_data", ReadDataW, 32'hFFFF_FF80);
      chk("lb_rd", RdW, 3);
      op(0, 2'b01, 32'h101, 0, 3'b100, 5'd3, 1, 0, 32'h0000_8000);
      chk("lbu_data", ReadDataW, 32'h0000_0080);

      // 4: LH / LHU
      op(0, 2'b01, 32'h102, 0, 3'b001, 5'd4, 1, 2, 32'h8001_0000);
      chk("lh_data", ReadDataW, 32'hFFFF_8001);
      op(0, 2'b01, 32'h102, 0, 3'b101, 5'd4, 1, 0, 32'h8001_0000);
      chk("lhu_data", ReadDataW, 32'h0000_8001);

      // extra lanes: SH upper half, LW, undefined funct3 as word
      op(1, 2'b00, 32'h102, 32'h1234_BEEF, 3'b001, 5'd0, 0, 1, 0);
      chk("sh_be", cap_be, 4'b1100);
      chk("sh_wdata", cap_wd, 32'hBEEF_BEEF);
      op(0, 2'b01, 32'h10C, 0, 3'b010, 5'd5, 1, 0, 32'hCAFE_F00D);
      chk("lw_data", ReadDataW, 32'hCAFE_F00D);
      op(0, 2'b01, 32'h110, 0, 3'b111, 5'd6, 1, 0, 32'h8765_4321);
      chk("lund_data", ReadDataW, 32'h8765_4321);

      // misaligned word load
      op(0, 2'b01, 32'h121, 0, 3'b010, 5'd8, 1, 0, 32'h1357_9BDF);
`ifdef PL_MEM_MISALIGN_TRAP_EN
      chk("mis_flag", MisalignW, 1);
      chk("mis_rw", RegWriteW, 0);
`else
      chk("mis_data", ReadDataW, 32'h1357_9BDF);
      chk("mis_rw", RegWriteW, 1);
`endif

      // ack while idle with an ALU op: ignored, fields pass through
      @(posedge clk); #1;
      RegWriteM = 1'b1; ResultSrcM = 2'b00; ALUResultM = 32'h1234;
      RdM = 5'd11; bus.bus_ack = 1'b1; bus.bus_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      RegWriteM = 1'b0; bus.bus_ack = 1'b0;
      @(negedge clk);
      chk("alu_rw", RegWriteW, 1);
      chk("alu_res", ALUResultW, 32'h1234);
      chk("alu_rdata", ReadDataW, 0);

      // 5: load timeout
      op(0, 2'b01, 32'h300, 0, 3'b010, 5'd9, 1, -1, 32'h1111_1111);
      chk("to_stalls", stalls, TIMEOUT);
      chk("to_buserr", BusErr, 1);
      chk("to_rw", RegWriteW, 0);
      chk("to_rdata", ReadDataW, 0);

      // 6: reset in WAIT, then a late ack
      @(posedge clk); #1;
      MemWriteM = 1'b0; ResultSrcM = 2'b01; ALUResultM = 32'h200;
      funct3M = 3'b010; RdM = 5'd7; RegWriteM = 1'b1;
      bus.bus_ack = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("r6_req", bus.bus_req, 0);
      chk("r6_stall", StallM, 0);
      chk("r6_pc", PCPlus4W, 0);
      chk("r6_alu", ALUResultW, 0);
      chk("r6_buserr", BusErr, 0);
      ResultSrcM = 2'b00; RegWriteM = 1'b0;
      bus.bus_ack = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.bus_ack = 1'b0;
      @(negedge clk);
      chk("r6_late_rw", RegWriteW, 0);
      chk("r6_late_rd", ReadDataW, 0);
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
